root_rank_acc_reg: RTL and testbench
====================================

Name: root_rank_acc_reg

Overview:
Parametrised register bank at the root node that merges V computation results arriving from child nodes into per-rank entries.
- Each write either overwrites an entry or accumulates into it (signed add).
- Provides NUM_RD independent registered read ports with write-to-read bypass.
- Includes a sequenced clear engine and a sticky overflow flag.
- Sits between the root merge datapath and the output/readback logic.

Parameters:
DATA_WIDTH, 16, width of one rank entry (signed two's complement)
RANK_WIDTH, 4, address width; depth = 2**RANK_WIDTH entries
NUM_RD, 2, number of independent read ports

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write enable
wr_mode  input  1  0 = overwrite, 1 = accumulate
wr_addr  input  RANK_WIDTH  write address
wr_data  input  DATA_WIDTH  write / addend data (signed)
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*RANK_WIDTH  flattened read addresses; port k at bits [k*RANK_WIDTH +: RANK_WIDTH]
rd_data  output  NUM_RD*DATA_WIDTH  flattened registered read data
rd_valid  output  NUM_RD  per-port read data valid
clr_start  input  1  pulse: begin clearing all entries
busy  output  1  clear engine active
clr_done  output  1  one-cycle pulse when clear completes
ovf  output  1  sticky accumulate-overflow flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries = 0; rd_data = 0; rd_valid = 0; busy = 0; clr_done = 0; ovf = 0.
  - FSM goes to IDLE; clear counter = 0.
- Write, IDLE only, on the clk edge where wr_en = 1:
  - wr_mode = 0: entry[wr_addr] <= wr_data.
  - wr_mode = 1: entry[wr_addr] <= entry[wr_addr] + wr_data, computed at DATA_WIDTH+1 bits.
- Overflow: sum outside [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] sets ovf. ovf stays set until reset or an accepted clr_start.
- Result stored on overflow: see Optional Feature.
- Read latency is one cycle:
  - Port k with rd_en[k] = 1 at edge N drives rd_valid[k] = 1 and rd_data[k] = entry value after edge N.
  - Same-cycle write to the same address is bypassed: read returns the newly written/accumulated value.
  - rd_en[k] = 0 drives rd_valid[k] = 0 and rd_data[k] = 0 next cycle.
  - Ports are fully independent; any ports may read the same address.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start: busy = 1 from the next cycle; counter = 0; ovf cleared.
  - In CLEAR, each cycle entry[counter] <= 0 and counter increments.
  - After entry 2**RANK_WIDTH-1 is cleared: CLEAR -> IDLE, busy = 0, clr_done = 1 for exactly one cycle.
  - Total busy duration = 2**RANK_WIDTH cycles.
- During CLEAR:
  - wr_en is ignored (writes dropped, no ovf update).
  - clr_start is ignored.
  - Reads are allowed and return current contents; the entry being cleared in that cycle reads as 0 (bypass).
- clr_start and wr_en in the same IDLE cycle: the write is performed, then the clear begins next cycle, so the write is ultimately cleared.
- rst_n asserted mid-CLEAR: immediate return to the reset state; no clr_done pulse.
- Address wrap is not applicable: all addresses are in range by construction.

Optional Feature:
ROOT_RANK_ACC_SAT_EN
- Defined: accumulate overflow saturates to 2**(DATA_WIDTH-1)-1 (positive) or -2**(DATA_WIDTH-1) (negative).
- Not defined: result wraps modulo 2**DATA_WIDTH.
- ovf is set on overflow in both builds.
- Overwrite mode is unaffected.

Test Plan:
1. Reset, then read addr 3 on port 0 -> rd_valid[0] = 1, rd_data[0] = 0x0000; ovf = 0, busy = 0.
2. Overwrite addr 5 = 0x0010, then accumulate 0x0005 twice -> port 1 read of addr 5 returns 0x001A; a same-cycle read during the second accumulate returns 0x001A (bypass).
3. Overwrite addr 2 = 0x7FF0, accumulate 0x0020 -> ovf = 1.
   - Read returns 0x7FFF with ROOT_RANK_ACC_SAT_EN.
   - Read returns 0x8010 without it.
4. Fill all 16 entries, pulse clr_start -> busy high for 16 cycles, clr_done pulse on cycle 17, all reads 0, ovf = 0.
   - A write to addr 7 issued mid-clear is dropped (addr 7 reads 0).
5. Both ports read addr 9 (holding 0x1234) while a write of 0x0ABC to addr 9 occurs -> both ports return 0x0ABC next cycle.
6. Assert rst_n low at clear cycle 8 -> busy = 0 and all outputs at reset values immediately; no clr_done pulse.

Source files
------------

// File: rtl/root_rank_acc_reg.sv
// Root-node rank register bank: overwrite/accumulate writes, NUM_RD registered read ports with
// write-to-read bypass, sequenced clear engine, sticky overflow. Saturation: ROOT_RANK_ACC_SAT_EN.
module root_rank_acc_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int RANK_WIDTH = 4,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic                         wr_mode,
    input  logic [RANK_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*RANK_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    input  logic                         clr_start,
    output logic                         busy,
    output logic                         clr_done,
    output logic                         ovf
);
    localparam int DEPTH = 2**RANK_WIDTH;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state, w_state_nxt;
    logic [RANK_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                  r_clr_done, w_clr_done_nxt;
    logic                  r_ovf, w_ovf_nxt;
    logic                  w_wr_act, w_clr_act;

    logic [DATA_WIDTH-1:0] r_mem     [DEPTH];
    logic [DATA_WIDTH-1:0] w_mem_nxt [DEPTH];

    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_acc_ovf;
    logic [DATA_WIDTH-1:0] w_acc_res;
    logic [DATA_WIDTH-1:0] w_wr_val;

    // Sign-extend both operands so the extra bit exposes signed overflow.
    assign w_old     = r_mem[wr_addr];
    assign w_sum     = {w_old[DATA_WIDTH-1], w_old} + {wr_data[DATA_WIDTH-1], wr_data};
    assign w_acc_ovf = w_sum[DATA_WIDTH] ^ w_sum[DATA_WIDTH-1];

`ifdef ROOT_RANK_ACC_SAT_EN
    assign w_acc_res = !w_acc_ovf        ? w_sum[DATA_WIDTH-1:0] :
                       w_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                           {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    assign w_acc_res = w_sum[DATA_WIDTH-1:0];
`endif

    assign w_wr_val = wr_mode ? w_acc_res : wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_clr_done <= w_clr_done_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_clr_done_nxt = 1'b0;
        w_ovf_nxt      = r_ovf;
        w_wr_act       = 1'b0;
        w_clr_act      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_act = wr_en;
                if (wr_en && wr_mode && w_acc_ovf)
                    w_ovf_nxt = 1'b1;
                // A same-cycle write still lands; the clear that follows wipes it.
                if (clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            S_CLEAR: begin
                w_clr_act = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == RANK_WIDTH'(DEPTH-1)) begin
                    w_state_nxt    = S_IDLE;
                    w_clr_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Post-edge contents; read ports sample this to get write/clear bypass for free.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
            if (w_wr_act && wr_addr == RANK_WIDTH'(i))
                w_mem_nxt[i] = w_wr_val;
            if (w_clr_act && r_cnt == RANK_WIDTH'(i))
                w_mem_nxt[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= w_mem_nxt[i];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [RANK_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_vld;

        assign w_ra = rd_addr[k*RANK_WIDTH +: RANK_WIDTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld  <= rd_en[k];
                r_data <= rd_en[k] ? w_mem_nxt[w_ra] : '0;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_data;
        assign rd_valid[k]                         = r_vld;
    end

    assign busy     = (r_state == S_CLEAR);
    assign clr_done = r_clr_done;
    assign ovf      = r_ovf;
endmodule

// File: tb/tb_root_rank_acc_reg.sv
// Bench for root_rank_acc_reg (default wrap build): vector table plus clear/reset sequences,
// expected results queued at drive time and compared once the registered outputs appear.
module tb_root_rank_acc_reg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_mode, clr_start;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_valid;
    logic        busy, clr_done, ovf;

    root_rank_acc_reg #(.DATA_WIDTH(16), .RANK_WIDTH(4), .NUM_RD(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .clr_start(clr_start), .busy(busy), .clr_done(clr_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, wm;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  re;
        logic [3:0]  ra0, ra1;
        logic [1:0]  ev;
        logic [15:0] e0, e1;
        logic        eo;
    } vec_t;

    typedef struct {
        string       nm;
        logic [1:0]  vld;
        logic [15:0] d0, d1;
        logic        ovf, busy, done;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic [1:0] v, input logic [15:0] d0,
                                input logic [15:0] d1, input logic o, input logic b, input logic d);
        exp_t e;
        e.nm = nm; e.vld = v; e.d0 = d0; e.d1 = d1; e.ovf = o; e.busy = b; e.done = d;
        return e;
    endfunction

    // One clock: drive, queue expectation, sample #1 after the edge, compare.
    task automatic cyc(input logic we, input logic wm, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1,
                       input logic clr, input exp_t e);
        exp_t x;
        wr_en = we; wr_mode = wm; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = {ra1, ra0}; clr_start = clr;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk({x.nm, ".vld"},  {30'd0, rd_valid}, {30'd0, x.vld});
        chk({x.nm, ".d0"},   {16'd0, rd_data[15:0]},  {16'd0, x.d0});
        chk({x.nm, ".d1"},   {16'd0, rd_data[31:16]}, {16'd0, x.d1});
        chk({x.nm, ".ovf"},  {31'd0, ovf},      {31'd0, x.ovf});
        chk({x.nm, ".busy"}, {31'd0, busy},     {31'd0, x.busy});
        chk({x.nm, ".done"}, {31'd0, clr_done}, {31'd0, x.done});
        wr_en = 1'b0; wr_mode = 1'b0; rd_en = 2'b00; clr_start = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".vld"},  {30'd0, rd_valid}, 32'd0);
        chk({nm, ".data"}, rd_data, 32'd0);
        chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ".done"}, {31'd0, clr_done}, 32'd0);
        chk({nm, ".ovf"},  {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[14];
        logic saw_done;
        // we wm  wa    wd        re     ra0   ra1   ev     e0        e1        eo
        tv[0]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b01, 4'd3, 4'd0, 2'b01, 16'h0000, 16'h0000, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 4'd5, 16'h0010, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 4'd5, 16'h0005, 2'b10, 4'd0, 4'd5, 2'b10, 16'h0000, 16'h0015, 1'b0};
        tv[3]  = '{1'b1, 1'b1, 4'd5, 16'h0005, 2'b11, 4'd5, 4'd5, 2'b11, 16'h001A, 16'h001A, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b10, 4'd0, 4'd5, 2'b10, 16'h0000, 16'h001A, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 4'd2, 16'h7FF0, 2'b01, 4'd2, 4'd0, 2'b01, 16'h7FF0, 16'h0000, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 4'd2, 16'h0020, 2'b01, 4'd2, 4'd0, 2'b01, 16'h8010, 16'h0000, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b11, 4'd2, 4'd5, 2'b11, 16'h8010, 16'h001A, 1'b1};
        tv[8]  = '{1'b1, 1'b0, 4'd9, 16'h1234, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        tv[9]  = '{1'b1, 1'b0, 4'd9, 16'h0ABC, 2'b11, 4'd9, 4'd9, 2'b11, 16'h0ABC, 16'h0ABC, 1'b1};
        tv[10] = '{1'b1, 1'b0, 4'd4, 16'h8000, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        tv[11] = '{1'b1, 1'b1, 4'd4, 16'hFFFF, 2'b10, 4'd0, 4'd4, 2'b10, 16'h0000, 16'h7FFF, 1'b1};
        tv[12] = '{1'b1, 1'b0, 4'd6, 16'h0003, 2'b00, 4'd0, 4'd0, 2'b00, 16'h0000, 16'h0000, 1'b1};
        tv[13] = '{1'b1, 1'b1, 4'd6, 16'hFFFB, 2'b01, 4'd6, 4'd0, 2'b01, 16'hFFFE, 16'h0000, 1'b1};

        rst_n = 1'b0; wr_en = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0; clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            cyc(tv[i].we, tv[i].wm, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra0, tv[i].ra1, 1'b0,
                mk($sformatf("vec%0d", i), tv[i].ev, tv[i].e0, tv[i].e1, tv[i].eo, 1'b0, 1'b0));

        // Clear: fill all, start with a simultaneous write, walk the 16 clear cycles.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 4'(i), 16'h1000 + 16'(i), 2'b00, 4'd0, 4'd0, 1'b0,
                mk($sformatf("fill%0d", i), 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 4'd1, 16'h0042, 2'b01, 4'd1, 4'd0, 1'b1,
            mk("clr_start", 2'b01, 16'h0042, 16'h0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 16; k++)
            cyc(k == 10, 1'b0, 4'd7, 16'h5555, 2'b11, 4'(k), 4'd15, k == 3,
                mk($sformatf("clr%0d", k), 2'b11, 16'h0, (k < 15) ? 16'h100F : 16'h0,
                   1'b0, k < 15, k == 15));
        cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 1'b0,
            mk("clr_after", 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0));
        for (int j = 0; j < 8; j++)
            cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 4'(2*j), 4'(2*j+1), 1'b0,
                mk($sformatf("cleared%0d", j), 2'b11, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0));

        // Reset in the middle of a clear.
        cyc(1'b1, 1'b1, 4'd15, 16'h0F0F, 2'b00, 4'd0, 4'd0, 1'b0,
            mk("pre_rst_wr", 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0));
        cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 4'd0, 4'd0, 1'b1,
            mk("rst_clr_start", 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 7; k++)
            cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b01, 4'd15, 4'd0, 1'b0,
                mk($sformatf("rclr%0d", k), 2'b01, 16'h0F0F, 16'h0, 1'b0, 1'b1, 1'b0));
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_clr_rst");
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            saw_done |= clr_done;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            saw_done |= clr_done | busy;
        end
        chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);
        cyc(1'b0, 1'b0, 4'd0, 16'h0, 2'b11, 4'd15, 4'd8, 1'b0,
            mk("post_rst_rd", 2'b11, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0));

        chk("sbq_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
